// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, busy scoreboard and commit trace
// Ports: clk, rst_n (async active-low); we/waddr/wdata: NWR packed write ports;
//        raddr/rdata/rbusy: NRD packed combinational read ports with pending-write flag;
//        rsv_en/rsv_addr: mark a register busy; upd_valid/upd_id/upd_val: registered commit trace.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                upd_valid,
  output logic [AW-1:0]       upd_id,
  output logic [XLEN-1:0]     upd_val
);
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            upd_valid_q, upd_valid_d;
  logic [AW-1:0]   upd_id_q, upd_id_d;
  logic [XLEN-1:0] upd_val_q, upd_val_d;
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  eff;
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;
  logic            hit;
  always_comb begin
    for (int i = 0; i < NWR; i++) begin
      wa[i]  = waddr[i*AW +: AW];
      wd[i]  = wdata[i*XLEN +: XLEN];
      eff[i] = we[i] && !(ZERO_REG != 0 && wa[i] == '0);
    end
  end
  // Ascending port scan: the highest-indexed matching write is the one that lands.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rv    = '0;
    hit   = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      ra  = raddr[j*AW +: AW];
      rv  = mem_q[ra];
      hit = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if (eff[i] && wa[i] == ra) begin
          rv  = wd[i];
          hit = 1'b1;
        end
      end
      rdata[j*XLEN +: XLEN] = (ZERO_REG != 0 && ra == '0) ? '0 : rv;
      rbusy[j] = busy_q[ra] && !hit && !(ZERO_REG != 0 && ra == '0);
    end
  end
  // Reserve is applied after write clears so a new producer keeps the register busy.
  always_comb begin
    mem_d       = mem_q;
    busy_d      = busy_q;
    upd_valid_d = 1'b0;
    upd_id_d    = '0;
    upd_val_d   = '0;
    for (int i = 0; i < NWR; i++) begin
      if (eff[i]) begin
        mem_d[wa[i]]  = wd[i];
        busy_d[wa[i]] = 1'b0;
        upd_valid_d   = 1'b1;
        upd_id_d      = wa[i];
        upd_val_d     = wd[i];
      end
    end
    if (rsv_en && (ZERO_REG == 0 || rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      busy_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_id_q    <= '0;
      upd_val_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      busy_q      <= busy_d;
      upd_valid_q <= upd_valid_d;
      upd_id_q    <= upd_id_d;
      upd_val_q   <= upd_val_d;
    end
  end
  assign upd_valid = upd_valid_q;
  assign upd_id    = upd_id_q;
  assign upd_val   = upd_val_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and pseudo-random checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [4:0]  ra [2];
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [9:0]  waddr, raddr;
  logic [63:0] wdata, rdata;
  logic [1:0]  rbusy;
  logic        upd_valid;
  logic [4:0]  upd_id;
  logic [31:0] upd_val;
  int tests = 0, fails = 0;
  bit en = 1'b0;
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  logic        m_uv;
  logic [4:0]  m_uid;
  logic [31:0] m_uval;

  always #5 clk = ~clk;
  assign waddr = {wa[1], wa[0]};
  assign wdata = {wd[1], wd[0]};
  assign raddr = {ra[1], ra[0]};

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .upd_valid(upd_valid), .upd_id(upd_id), .upd_val(upd_val)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural model: a write lands unless it targets r0; later ports overwrite
  // earlier ones; a reservation marks the register busy after any write clears it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin
        m_mem[k]  <= 32'h0;
        m_busy[k] <= 1'b0;
      end
      m_uv   <= 1'b0;
      m_uid  <= 5'd0;
      m_uval <= 32'h0;
    end else begin
      m_uv   <= 1'b0;
      m_uid  <= 5'd0;
      m_uval <= 32'h0;
      for (int i = 0; i < 2; i++)
        if (we[i] && wa[i] != 5'd0) begin
          m_mem[wa[i]]  <= wd[i];
          m_busy[wa[i]] <= 1'b0;
          m_uv          <= 1'b1;
          m_uid         <= wa[i];
          m_uval        <= wd[i];
        end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("model_upd_valid", {31'd0, upd_valid}, {31'd0, m_uv});
      chk("model_upd_id", {27'd0, upd_id}, {27'd0, m_uid});
      chk("model_upd_val", upd_val, m_uval);
      for (int j = 0; j < 2; j++) begin
        logic [31:0] e;
        bit h;
        e = m_mem[ra[j]];
        h = 1'b0;
        for (int i = 0; i < 2; i++)
          if (we[i] && wa[i] != 5'd0 && wa[i] == ra[j]) begin
            e = wd[i];
            h = 1'b1;
          end
        if (ra[j] == 5'd0) e = 32'h0;
        chk("model_rdata", rdata[j*32 +: 32], e);
        chk("model_rbusy", {31'd0, rbusy[j]}, {31'd0, ra[j] != 5'd0 && m_busy[ra[j]] && !h});
      end
    end
  end

  initial begin
    rst_n = 1'b0; we = 2'b00; wa = '{5'd0, 5'd0}; wd = '{32'h0, 32'h0};
    ra = '{5'd0, 5'd0}; rsv_en = 1'b0; rsv_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;
    // reset state across every register
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a);
      #2;
      chk("rst_rdata", rdata[31:0], 32'h0);
      chk("rst_rbusy", {31'd0, rbusy[0]}, 32'h0);
      chk("rst_upd_valid", {31'd0, upd_valid}, 32'h0);
      step();
    end
    // single write with bypass, then stored value and trace
    we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
    #2 chk("byp_w5", rdata[31:0], 32'hDEADBEEF);
    step(); we = 2'b00;
    #2 chk("stored_w5", rdata[31:0], 32'hDEADBEEF);
    chk("trace_v_w5", {31'd0, upd_valid}, 32'd1);
    chk("trace_id_w5", {27'd0, upd_id}, 32'd5);
    chk("trace_val_w5", upd_val, 32'hDEADBEEF);
    // same-address collision: port 1 wins
    step();
    we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h1111; wd[1] = 32'h2222;
    ra[0] = 5'd7; ra[1] = 5'd7;
    #2 chk("coll_byp0", rdata[31:0], 32'h2222);
    chk("coll_byp1", rdata[63:32], 32'h2222);
    step(); we = 2'b00;
    #2 chk("coll_stored", rdata[31:0], 32'h2222);
    chk("coll_upd_val", upd_val, 32'h2222);
    // writes to r0 are dropped everywhere
    step();
    we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ra[0] = 5'd0;
    #2 chk("r0_byp", rdata[31:0], 32'h0);
    step(); we = 2'b00;
    #2 chk("r0_stored", rdata[31:0], 32'h0);
    chk("r0_upd_valid", {31'd0, upd_valid}, 32'd0);
    // two different targets: trace reports port 1
    step();
    we = 2'b11; wa[0] = 5'd2; wa[1] = 5'd4; wd[0] = 32'hA2; wd[1] = 32'hB4;
    step(); we = 2'b00;
    #2 chk("dual_upd_id", {27'd0, upd_id}, 32'd4);
    chk("dual_upd_val", upd_val, 32'hB4);
    // scoreboard: reserve, write clears, reserve+write keeps busy
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step(); rsv_en = 1'b0; ra[0] = 5'd3; ra[1] = 5'd3;
    #2 chk("rsv_busy0", {31'd0, rbusy[0]}, 32'd1);
    chk("rsv_busy1", {31'd0, rbusy[1]}, 32'd1);
    step();
    we = 2'b01; wa[0] = 5'd3; wd[0] = 32'hAB;
    #2 chk("wr_unbusy_comb", {31'd0, rbusy[0]}, 32'd0);
    step(); we = 2'b00;
    #2 chk("wr_unbusy_reg", {31'd0, rbusy[0]}, 32'd0);
    chk("wr3_stored", rdata[31:0], 32'hAB);
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3; we = 2'b01; wa[0] = 5'd3; wd[0] = 32'hCD;
    step(); rsv_en = 1'b0; we = 2'b00;
    #2 chk("rsv_wr_busy", {31'd0, rbusy[0]}, 32'd1);
    chk("rsv_wr_data", rdata[31:0], 32'hCD);
    // reserving r0 is ignored
    step();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step(); rsv_en = 1'b0; ra[0] = 5'd0;
    #2 chk("rsv_r0", {31'd0, rbusy[0]}, 32'd0);
    // pseudo-random traffic, checked by the model every cycle
    for (int k = 0; k < 60; k++) begin
      step();
      we = 2'($urandom); wa[0] = 5'($urandom); wa[1] = 5'($urandom);
      wd[0] = $urandom; wd[1] = $urandom; ra[0] = 5'($urandom); ra[1] = 5'($urandom);
      rsv_en = 1'($urandom); rsv_addr = 5'($urandom);
      if (k % 7 == 0) ra[0] = wa[1];
    end
    // mid-cycle reset clears everything immediately
    step();
    we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd10;
    step(); we = 2'b00; rsv_en = 1'b0; ra[0] = 5'd9; ra[1] = 5'd10;
    #2 chk("pre_rst_r9", rdata[31:0], 32'h55);
    chk("pre_rst_busy10", {31'd0, rbusy[1]}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_rst_r9", rdata[31:0], 32'h0);
    chk("mid_rst_busy10", {31'd0, rbusy[1]}, 32'd0);
    chk("mid_rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("mid_rst_upd_val", upd_val, 32'h0);
    step();
    we = 2'b01; wa[0] = 5'd12; wd[0] = 32'h77; ra[0] = 5'd12; rsv_en = 1'b1; rsv_addr = 5'd12;
    #2 chk("rst_bypass", rdata[31:0], 32'h77);
    step(); we = 2'b00; rsv_en = 1'b0;
    #2 chk("rst_write_ignored", rdata[31:0], 32'h0);
    chk("rst_rsv_ignored", {31'd0, rbusy[0]}, 32'd0);
    rst_n = 1'b1;
    step();
    we = 2'b10; wa[1] = 5'd12; wd[1] = 32'h99;
    step(); we = 2'b00;
    #2 chk("post_rst_write", rdata[31:0], 32'h99);
    chk("post_rst_upd_id", {27'd0, upd_id}, 32'd12);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
